// File: rtl/fp_add_driver.sv
// fp_add_driver: issues buffered operand pairs to a floating-point adder through
// its start/done handshake. Results go out on a valid/ready port, and a watchdog
// aborts any operation whose adder never completes.
`timescale 1ns/1ps
module fp_add_driver #(
    parameter int W            = 32,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_sum,
    output logic                     add_start,
    input  logic                     add_done,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    input  logic [W-1:0]             add_sum,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SCW = $clog2(START_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        HOLD    = 3'd2,
        BUSY    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [2*W-1:0]      mem [DEPTH];
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]         count_reg;
    logic [SCW-1:0]      start_cnt_reg;
    logic [TW-1:0]       timer_reg;
    logic [W-1:0]        add_a_reg, add_b_reg, res_sum_reg;
    logic                res_valid_reg, add_start_reg, busy_reg, err_reg;

    logic                push, pop, timer_expired, capture_fire, abort;
    logic                add_start_next, busy_next;
    logic [2*W-1:0]      head_data;

    // FIFO handshake: full blocks pushes even when a pop happens in the same cycle
    assign in_ready      = (count_reg != (AW+1)'(DEPTH));
    assign push          = in_valid && in_ready;
    assign pop           = (state_reg == IDLE) && (count_reg != '0) && add_done;
    assign head_data     = mem[rd_ptr_reg];
    assign timer_expired = (timer_reg == TW'(TIMEOUT - 1));

    // Operand storage; no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_a, in_b};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the watchdog wins over normal progress in HOLD/BUSY
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (pop) state_next = START;
            START:   if (start_cnt_reg == SCW'(START_CYCLES - 1)) state_next = HOLD;
            HOLD: begin
                if (timer_expired)  state_next = IDLE;
                else if (!add_done) state_next = BUSY;
            end
            BUSY: begin
                if (timer_expired) state_next = IDLE;
                else if (add_done) state_next = CAPTURE;
            end
            CAPTURE: if (!res_valid_reg || res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: values loaded into the registered outputs on the next edge
    always_comb begin
        add_start_next = (state_next == START);
        busy_next      = (state_next != IDLE);
        capture_fire   = (state_reg == CAPTURE) && (!res_valid_reg || res_ready);
        abort          = ((state_reg == HOLD) || (state_reg == BUSY)) && timer_expired;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (pop && !push) count_reg <= count_reg - (AW+1)'(1);
        end
    end

    // Operation datapath: start counter, watchdog timer, adder operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_cnt_reg <= '0;
            timer_reg     <= '0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
        end else begin
            if (pop) begin
                start_cnt_reg <= '0;
                add_a_reg     <= head_data[2*W-1:W];
                add_b_reg     <= head_data[W-1:0];
            end else if (state_reg == START) begin
                start_cnt_reg <= start_cnt_reg + SCW'(1);
            end
            if (state_reg == START) begin
                timer_reg <= '0;
            end else if ((state_reg == HOLD) || (state_reg == BUSY)) begin
                timer_reg <= timer_reg + TW'(1);
            end
        end
    end

    // Result register, sticky error flag and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sum_reg   <= '0;
            res_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            add_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (capture_fire) begin
                res_sum_reg   <= add_sum;
                res_valid_reg <= 1'b1;
            end else if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
            if (abort)        err_reg <= 1'b1;
            else if (err_clr) err_reg <= 1'b0;
            add_start_reg <= add_start_next;
            busy_reg      <= busy_next;
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_sum     = res_sum_reg;
    assign add_start   = add_start_reg;
    assign add_a       = add_a_reg;
    assign add_b       = add_b_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;
    assign fifo_count  = count_reg;

endmodule

// File: doc/fp_add_driver.md
# fp_add_driver

Initiator for the floating-point adder's start/done handshake. It accepts operand pairs on a valid/ready stream into a small FIFO and issues each pair to the adder by pulsing `add_start`. It holds the operands stable until the adder returns to its done state, then delivers the sum on a valid/ready result port. It sits between the operand source (bus or test harness) and the adder datapath/controller, and detects adders that never complete.

## Interface
Parameters:
- `W`, 32: operand/result width.
- `DEPTH`, 4: request FIFO depth; power of 2, at least 2.
- `START_CYCLES`, 2: cycles `add_start` is held high per operation, at least 1.
- `TIMEOUT`, 64: max cycles spent in HOLD+BUSY before abort, at least 4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a`, `in_b` in W: operands.
- `res_valid` out 1: result register full.
- `res_ready` in 1: consumer accepts result.
- `res_sum` out W: result.
- `add_start` out 1: start to adder.
- `add_done` in 1: adder done (high while adder idle).
- `add_a`, `add_b` out W: operands to adder, held registered.
- `add_sum` in W: adder result.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: sticky abort flag.
- `err_clr` in 1: clears `timeout_err`.
- `fifo_count` out log2(DEPTH)+1: occupancy.

## Operation
- FIFO:
  - Push on `in_valid & in_ready`; `in_ready = (fifo_count != DEPTH)`, combinational.
  - Pop only from IDLE.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full is ignored, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- IDLE:
  - If FIFO non-empty and `add_done=1`: pop head into `add_a`/`add_b`, clear start counter, go to START.
  - Otherwise stay.
- START:
  - `add_start=1`; counter increments each cycle.
  - After START_CYCLES cycles in START, go to HOLD.
- HOLD:
  - `add_start=0`; wait for `add_done=0`, then go to BUSY.
- BUSY:
  - Wait for `add_done=1`, then go to CAPTURE.
- CAPTURE:
  - If `!res_valid | res_ready`: load `res_sum<=add_sum`, set `res_valid=1`, go to IDLE.
  - Otherwise stay (adder sum is stable while the adder is idle).
- Result register:
  - `res_valid` clears on `res_valid & res_ready` unless reloaded in the same cycle.
- `add_a`/`add_b`: change only on pop; stable from START through CAPTURE.
- Timeout:
  - Timer cleared on entering HOLD; increments every cycle in HOLD or BUSY.
  - When it reaches TIMEOUT-1 while still in HOLD/BUSY: set `timeout_err`, go to IDLE, discard the operation (no result).
- `timeout_err`:
  - Set has priority over `err_clr` in the same cycle.
  - Remains set until `err_clr`.
  - Does not block further operations.
- Reset (async, also mid-operation):
  - State IDLE; FIFO emptied.
  - `add_start=0`, `res_valid=0`, `res_sum=0`, `add_a=add_b=0`, `timeout_err=0`, `busy=0`, `fifo_count=0`, `in_ready=1`.
  - Any in-flight operation and buffered result are lost.

## Timing
- Push at edge t: `fifo_count` updates at t; earliest pop at edge t+1 (if `add_done=1`).
- Pop at edge p:
  - `add_start` high for cycles p..p+START_CYCLES-1 (registered output, asserted at edge p).
  - HOLD begins at edge p+START_CYCLES.
- `add_done` low sampled at edge h → BUSY at h.
- `add_done` high sampled at edge b → CAPTURE at b.
- `res_valid` high at edge b+1 at earliest.
- Minimum result latency: pop-to-`res_valid` = START_CYCLES + 2 + adder busy cycles.
- Back-to-back operations: next pop no earlier than the edge after CAPTURE completes; one operation in flight at a time.
- `busy` is registered with the state.
- All outputs except `in_ready` are registered.

## Test plan
- Single op, behavioural adder model (done drops 1 cycle after start sampled high, busy 6 cycles after start falls):
  - Push a=0x3F800000, b=0x40000000.
  - Required: `add_start` high exactly 2 cycles, operands stable until capture, `res_sum`=0x40400000 with `res_valid` for one handshake, `busy` back to 0.
- Three pushes back-to-back:
  - Results arrive in push order.
  - `fifo_count` goes 1,2,3 then decrements per pop.
  - No `add_start` while `add_done=0`.
- Fill FIFO (4 pushes while adder busy), 5th `in_valid`:
  - `in_ready=0`; 5th pair is not accepted; count stays 4.
  - After one pop, `in_ready=1`.
- `res_ready=0` with 2 ops queued:
  - First result held.
  - Second op parks in CAPTURE, no third pop.
  - Raising `res_ready` delivers both in order.
- Adder model never raises `add_done` after start:
  - Abort after TIMEOUT cycles; `timeout_err=1`; no `res_valid`.
  - Next queued op proceeds normally.
  - `err_clr` clears flag; `err_clr` coincident with a new timeout leaves flag set.
- Assert `rst` during BUSY with 2 entries queued:
  - Outputs go to reset values asynchronously; `fifo_count=0`.
  - No result is produced after release.
